// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller between the pipeline and an 8-bit RAM port.
// It arbitrates IF fetches against MEM loads/stores, with MEM taking priority, and
// splits each access into 1, 2 or 4 little-endian byte transfers. A one-cycle done
// pulse returns the assembled data.
// Optional feature: define MEMCTRL_IF_ABORT_EN to let a MEM request abort an IF
// fetch that is still in the RD state.
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_done_o,
    output logic [31:0]       if_data_o,
    input  logic              ram_r_req_i,
    input  logic              ram_w_req_i,
    input  logic [ADDR_W-1:0] ram_addr_i,
    input  logic [31:0]       ram_w_data_i,
    input  logic [1:0]        ram_state_i,
    output logic              ram_done_o,
    output logic [31:0]       ram_r_data_o,
    input  logic [7:0]        mem_din_i,
    output logic [7:0]        mem_dout_o,
    output logic [ADDR_W-1:0] mem_a_o,
    output logic              mem_wr_o
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t            state;
    logic              owner_mem;     // 1 = MEM stage owns the transfer, 0 = IF
    logic [1:0]        n_last;        // index of the last byte (N-1)
    logic [2:0]        cyc;           // cycle index inside RD/WR
    logic [ADDR_W-1:0] base;
    logic [31:0]       wdata;
    logic [31:0]       rd_bytes;
    logic [31:0]       rd_bytes_next;

    logic              mem_req;
    logic              accept_mem;
    logic              accept_if;
    logic              accept;
    logic              capture;
    logic              abort;
    logic              rd_last;
    logic [1:0]        lane;
    logic [1:0]        next_idx;
    logic [ADDR_W-1:0] next_addr;
    logic [7:0]        wbyte;
    logic [1:0]        req_n_last;

    assign mem_req    = ram_r_req_i | ram_w_req_i;
    assign accept_mem = (state == IDLE) && mem_req;
    assign accept_if  = (state == IDLE) && !mem_req && if_req_i;
    assign accept     = accept_mem | accept_if;

`ifdef MEMCTRL_IF_ABORT_EN
    assign abort = (state == RD) && !owner_mem && mem_req;
`else
    assign abort = 1'b0;
`endif

    // Returned bytes lag their address by one cycle, so lane = cyc - 1.
    assign capture   = (state == RD) && (cyc != 3'd0) && !abort;
    assign lane      = cyc[1:0] - 2'd1;
    assign rd_last   = (cyc == ({1'b0, n_last} + 3'd1));
    assign next_idx  = cyc[1:0] + 2'd1;
    assign next_addr = base + ADDR_W'(next_idx);

    // Decode the size code into the index of the last byte; 10 is treated as a word.
    always_comb begin
        req_n_last = 2'd3;
        case (ram_state_i)
            2'b00:   req_n_last = 2'd0;
            2'b01:   req_n_last = 2'd1;
            default: req_n_last = 2'd3;
        endcase
    end

    // Merge the byte arriving this cycle into the read assembly buffer and pick the next store byte.
    always_comb begin
        rd_bytes_next                 = rd_bytes;
        rd_bytes_next[8*lane +: 8]    = mem_din_i;
        wbyte                         = wdata[8*next_idx +: 8];
    end

    // Latch the request payload on accept and collect read bytes; pure data, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            base     <= accept_mem ? ram_addr_i : if_addr_i;
            wdata    <= ram_w_data_i;
            rd_bytes <= '0;
        end else if (capture) begin
            rd_bytes <= rd_bytes_next;
        end
    end

    // Transfer FSM with registered RAM-port and done outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            owner_mem    <= 1'b0;
            n_last       <= 2'd0;
            cyc          <= 3'd0;
            if_done_o    <= 1'b0;
            ram_done_o   <= 1'b0;
            if_data_o    <= '0;
            ram_r_data_o <= '0;
            mem_a_o      <= '0;
            mem_dout_o   <= '0;
            mem_wr_o     <= 1'b0;
        end else begin
            if_done_o  <= 1'b0;
            ram_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_mem) begin
                        owner_mem <= 1'b1;
                        n_last    <= req_n_last;
                        cyc       <= 3'd0;
                        mem_a_o   <= ram_addr_i;
                        if (ram_w_req_i) begin
                            state      <= WR;
                            mem_wr_o   <= 1'b1;
                            mem_dout_o <= ram_w_data_i[7:0];
                        end else begin
                            state <= RD;
                        end
                    end else if (accept_if) begin
                        owner_mem <= 1'b0;
                        n_last    <= 2'd3;
                        cyc       <= 3'd0;
                        mem_a_o   <= if_addr_i;
                        state     <= RD;
                    end
                end
                RD: begin
                    if (abort) begin
                        state   <= IDLE;
                        cyc     <= 3'd0;
                        mem_a_o <= '0;
                    end else if (rd_last) begin
                        state   <= DONE;
                        mem_a_o <= '0;
                        if (owner_mem) begin
                            ram_done_o   <= 1'b1;
                            ram_r_data_o <= rd_bytes_next;
                        end else begin
                            if_done_o <= 1'b1;
                            if_data_o <= rd_bytes_next;
                        end
                    end else begin
                        cyc <= cyc + 3'd1;
                        if (cyc < {1'b0, n_last}) begin
                            mem_a_o <= next_addr;
                        end else begin
                            mem_a_o <= '0;
                        end
                    end
                end
                WR: begin
                    if (cyc < {1'b0, n_last}) begin
                        cyc        <= cyc + 3'd1;
                        mem_a_o    <= next_addr;
                        mem_dout_o <= wbyte;
                        mem_wr_o   <= 1'b1;
                    end else begin
                        state      <= DONE;
                        mem_wr_o   <= 1'b0;
                        mem_a_o    <= '0;
                        mem_dout_o <= '0;
                        if (owner_mem) begin
                            ram_done_o <= 1'b1;
                        end else begin
                            if_done_o <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed bench for mem_ctrl with a 256-byte RAM model (one-cycle read latency).
module tb_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_done_o;
    logic [31:0] if_data_o;
    logic        ram_r_req_i;
    logic        ram_w_req_i;
    logic [31:0] ram_addr_i;
    logic [31:0] ram_w_data_i;
    logic [1:0]  ram_state_i;
    logic        ram_done_o;
    logic [31:0] ram_r_data_o;
    logic [7:0]  mem_din_i;
    logic [7:0]  mem_dout_o;
    logic [31:0] mem_a_o;
    logic        mem_wr_o;

    logic [7:0]  ram [0:255];
    logic        preload;
    int          n_assert;
    int          n_fail;

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_done_o    (if_done_o),
        .if_data_o    (if_data_o),
        .ram_r_req_i  (ram_r_req_i),
        .ram_w_req_i  (ram_w_req_i),
        .ram_addr_i   (ram_addr_i),
        .ram_w_data_i (ram_w_data_i),
        .ram_state_i  (ram_state_i),
        .ram_done_o   (ram_done_o),
        .ram_r_data_o (ram_r_data_o),
        .mem_din_i    (mem_din_i),
        .mem_dout_o   (mem_dout_o),
        .mem_a_o      (mem_a_o),
        .mem_wr_o     (mem_wr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: synchronous write, read data one cycle after the address.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
            ram[8'h00] <= 8'h11; ram[8'h01] <= 8'h22; ram[8'h02] <= 8'h33; ram[8'h03] <= 8'h44;
            ram[8'h04] <= 8'h55; ram[8'h05] <= 8'h66; ram[8'h06] <= 8'h77; ram[8'h07] <= 8'h88;
            ram[8'h08] <= 8'hA5;
            ram[8'h40] <= 8'h93; ram[8'h41] <= 8'h82; ram[8'h42] <= 8'h71; ram[8'h43] <= 8'h60;
        end else if (mem_wr_o) begin
            ram[mem_a_o[7:0]] <= mem_dout_o;
        end
        mem_din_i <= ram[mem_a_o[7:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_assert     = 0;
        n_fail       = 0;
        preload      = 1'b1;
        rst          = 1'b1;
        if_req_i     = 1'b0;
        if_addr_i    = 32'h0;
        ram_r_req_i  = 1'b0;
        ram_w_req_i  = 1'b0;
        ram_addr_i   = 32'h0;
        ram_w_data_i = 32'h0;
        ram_state_i  = 2'b00;
        #2;
        chk("rst_if_done",  {31'b0, if_done_o},  32'h0);
        chk("rst_ram_done", {31'b0, ram_done_o}, 32'h0);
        chk("rst_mem_wr",   {31'b0, mem_wr_o},   32'h0);
        chk("rst_if_data",  if_data_o,           32'h0);
        chk("rst_ram_data", ram_r_data_o,        32'h0);
        chk("rst_mem_a",    mem_a_o,             32'h0);
        chk("rst_mem_dout", {24'b0, mem_dout_o}, 32'h0);
        step();
        step();
        preload = 1'b0;
        rst     = 1'b0;
        step();

        // LW at 0x100: addresses in cycles 1..4, done in cycle 6
        ram_r_req_i = 1'b1; ram_addr_i = 32'h100; ram_state_i = 2'b11;
        chk("lw_c0_a", mem_a_o, 32'h0);
        step(); chk("lw_c1_a", mem_a_o, 32'h100); chk("lw_c1_wr", {31'b0, mem_wr_o}, 32'h0);
        step(); chk("lw_c2_a", mem_a_o, 32'h101);
        step(); chk("lw_c3_a", mem_a_o, 32'h102);
        step(); chk("lw_c4_a", mem_a_o, 32'h103);
        step(); chk("lw_c5_done", {31'b0, ram_done_o}, 32'h0); chk("lw_c5_a", mem_a_o, 32'h0);
        step(); chk("lw_c6_done", {31'b0, ram_done_o}, 32'h1);
        chk("lw_c6_data", ram_r_data_o, 32'h44332211);
        chk("lw_c6_ifdone", {31'b0, if_done_o}, 32'h0);
        ram_r_req_i = 1'b0;
        step(); chk("lw_c7_done", {31'b0, ram_done_o}, 32'h0);
        chk("lw_c7_hold", ram_r_data_o, 32'h44332211);

        // SB to 0x20 with 0xDEADBEEF: one write of 0xEF, done in cycle 2
        ram_w_req_i = 1'b1; ram_addr_i = 32'h20; ram_w_data_i = 32'hDEADBEEF; ram_state_i = 2'b00;
        step(); chk("sb_c1_wr", {31'b0, mem_wr_o}, 32'h1); chk("sb_c1_a", mem_a_o, 32'h20);
        chk("sb_c1_dout", {24'b0, mem_dout_o}, 32'hEF);
        step(); chk("sb_c2_done", {31'b0, ram_done_o}, 32'h1); chk("sb_c2_wr", {31'b0, mem_wr_o}, 32'h0);
        ram_w_req_i = 1'b0;
        step(); chk("sb_c3_wr", {31'b0, mem_wr_o}, 32'h0); chk("sb_c3_done", {31'b0, ram_done_o}, 32'h0);
        chk("sb_ram20", {24'b0, ram[8'h20]}, 32'hEF);
        chk("sb_ram21", {24'b0, ram[8'h21]}, 32'h00);

        // SH to 0xFFFFFFFF with 0x1234: wraps to address 0
        ram_w_req_i = 1'b1; ram_addr_i = 32'hFFFFFFFF; ram_w_data_i = 32'h00001234; ram_state_i = 2'b01;
        step(); chk("sh_c1_a", mem_a_o, 32'hFFFFFFFF); chk("sh_c1_dout", {24'b0, mem_dout_o}, 32'h34);
        chk("sh_c1_wr", {31'b0, mem_wr_o}, 32'h1);
        step(); chk("sh_c2_a", mem_a_o, 32'h0); chk("sh_c2_dout", {24'b0, mem_dout_o}, 32'h12);
        chk("sh_c2_wr", {31'b0, mem_wr_o}, 32'h1);
        step(); chk("sh_c3_done", {31'b0, ram_done_o}, 32'h1); chk("sh_c3_wr", {31'b0, mem_wr_o}, 32'h0);
        ram_w_req_i = 1'b0;
        step();

        // IF and LB at 0x8 together: load done cycle 3, fetch accepted 4, if_done cycle 10
        if_req_i = 1'b1; if_addr_i = 32'h40;
        ram_r_req_i = 1'b1; ram_addr_i = 32'h8; ram_state_i = 2'b00;
        step(); chk("arb_c1_a", mem_a_o, 32'h8);
        step();
        step(); chk("arb_c3_rdone", {31'b0, ram_done_o}, 32'h1); chk("arb_c3_data", ram_r_data_o, 32'h000000A5);
        chk("arb_c3_ifdone", {31'b0, if_done_o}, 32'h0);
        ram_r_req_i = 1'b0;
        step(); chk("arb_c4_a", mem_a_o, 32'h0);
        step(); chk("arb_c5_a", mem_a_o, 32'h40);
        step(); step(); step();
        step(); chk("arb_c9_ifdone", {31'b0, if_done_o}, 32'h0);
        step(); chk("arb_c10_ifdone", {31'b0, if_done_o}, 32'h1); chk("arb_c10_data", if_data_o, 32'h60718293);
        chk("arb_c10_rdone", {31'b0, ram_done_o}, 32'h0);
        if_req_i = 1'b0;
        step();

        // Fetch at 0x40, LW at 0x104 arrives in cycle 2
        if_req_i = 1'b1; if_addr_i = 32'h40;
        step();
        step();
        ram_r_req_i = 1'b1; ram_addr_i = 32'h104; ram_state_i = 2'b11;
`ifdef MEMCTRL_IF_ABORT_EN
        step(); chk("ab_c3_a", mem_a_o, 32'h0);
        step(); chk("ab_c4_a", mem_a_o, 32'h104);
        step(); chk("ab_c5_ifdone", {31'b0, if_done_o}, 32'h0);
        step(); chk("ab_c6_ifdone", {31'b0, if_done_o}, 32'h0);
        step(); step();
        step(); chk("ab_c9_rdone", {31'b0, ram_done_o}, 32'h1); chk("ab_c9_data", ram_r_data_o, 32'h88776655);
        chk("ab_c9_ifdone", {31'b0, if_done_o}, 32'h0);
        ram_r_req_i = 1'b0;
        step(); chk("ab_c10_a", mem_a_o, 32'h0);
        step(); chk("ab_c11_a", mem_a_o, 32'h40);
        step(); step(); step(); step();
        step(); chk("ab_c16_ifdone", {31'b0, if_done_o}, 32'h1); chk("ab_c16_data", if_data_o, 32'h60718293);
        if_req_i = 1'b0;
        step();
`else
        step(); chk("na_c3_a", mem_a_o, 32'h42);
        step(); step();
        step(); chk("na_c6_ifdone", {31'b0, if_done_o}, 32'h1); chk("na_c6_data", if_data_o, 32'h60718293);
        chk("na_c6_rdone", {31'b0, ram_done_o}, 32'h0);
        if_req_i = 1'b0;
        step(); chk("na_c7_a", mem_a_o, 32'h0);
        step(); chk("na_c8_a", mem_a_o, 32'h104);
        step(); step(); step(); step();
        step(); chk("na_c13_rdone", {31'b0, ram_done_o}, 32'h1); chk("na_c13_data", ram_r_data_o, 32'h88776655);
        ram_r_req_i = 1'b0;
        step();
`endif

        // SW to 0x30, reset pulsed in cycle 2
        ram_w_req_i = 1'b1; ram_addr_i = 32'h30; ram_w_data_i = 32'hCAFEF00D; ram_state_i = 2'b11;
        step(); chk("sw_c1_wr", {31'b0, mem_wr_o}, 32'h1);
        step();
        rst = 1'b1; ram_w_req_i = 1'b0;
        #1;
        chk("rsw_mem_wr", {31'b0, mem_wr_o}, 32'h0);
        chk("rsw_mem_a", mem_a_o, 32'h0);
        chk("rsw_mem_dout", {24'b0, mem_dout_o}, 32'h0);
        chk("rsw_ram_data", ram_r_data_o, 32'h0);
        chk("rsw_if_data", if_data_o, 32'h0);
        step();
        rst = 1'b0;
        chk("rsw_rdone", {31'b0, ram_done_o}, 32'h0);
        chk("rsw_ram30", {24'b0, ram[8'h30]}, 32'h0D);
        chk("rsw_ram31", {24'b0, ram[8'h31]}, 32'h00);
        step(); chk("rsw_idle_wr", {31'b0, mem_wr_o}, 32'h0); chk("rsw_idle_done", {31'b0, ram_done_o}, 32'h0);

        // LB at 0x8 after reset release completes in 3 cycles
        ram_r_req_i = 1'b1; ram_addr_i = 32'h8; ram_state_i = 2'b00;
        step(); chk("lb_c1_a", mem_a_o, 32'h8);
        step(); chk("lb_c2_done", {31'b0, ram_done_o}, 32'h0);
        step(); chk("lb_c3_done", {31'b0, ram_done_o}, 32'h1); chk("lb_c3_data", ram_r_data_o, 32'h000000A5);
        ram_r_req_i = 1'b0;
        step(); chk("lb_c4_done", {31'b0, ram_done_o}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller between the pipeline and the 8-bit unified RAM port. It arbitrates instruction fetches from the IF stage against load/store requests from the MEM stage. It splits each request into 1, 2 or 4 little-endian byte transfers and returns a one-cycle `done` pulse with the assembled data. The MEM stage holds its request and stalls until that pulse arrives.

## Interface
Parameters:
- `ADDR_W`, 32: address width for all address ports.

Ports:
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `if_req_i`  in  1: IF fetch request; held until `if_done_o`.
- `if_addr_i`  in  32: fetch address (always a 4-byte access).
- `if_done_o`  out  1: one-cycle pulse; `if_data_o` valid in the same cycle.
- `if_data_o`  out  32: fetched instruction word.
- `ram_r_req_i`  in  1: MEM load request.
- `ram_w_req_i`  in  1: MEM store request; never asserted together with `ram_r_req_i`.
- `ram_addr_i`  in  32: load/store byte address.
- `ram_w_data_i`  in  32: store data; low bytes are used first.
- `ram_state_i`  in  2: size code: `00` = 1 byte, `01` = 2 bytes, `11` = 4 bytes, `10` = treated as 4 bytes.
- `ram_done_o`  out  1: one-cycle pulse that ends a MEM access.
- `ram_r_data_o`  out  32: raw little-endian load data, zero above the accessed size; valid while `ram_done_o` is high.
- `mem_din_i`  in  8: RAM read byte, returned one cycle after its address.
- `mem_dout_o`  out  8: RAM write byte.
- `mem_a_o`  out  32: RAM byte address.
- `mem_wr_o`  out  1: 1 = write `mem_dout_o` to `mem_a_o` this cycle.

## Operation
States:
- `IDLE`: no transfer in progress.
- `RD`: issuing read byte addresses and collecting returned bytes.
- `WR`: issuing write bytes.
- `DONE`: one cycle in which the selected done pulse is high.

Request handling:
- In `IDLE`, the controller samples the requests at the clock edge.
- Priority: a MEM request (`ram_r_req_i` or `ram_w_req_i`) wins over `if_req_i`.
- On accept, the controller latches the address, the size N (1, 2 or 4), the store data and the owner (IF or MEM).
- The next state is `RD` for a load or fetch, and `WR` for a store.

`RD` state:
- Drives `mem_a_o` = base+i for i = 0..N-1 on consecutive cycles, with `mem_wr_o` = 0.
- Captures `mem_din_i` one cycle later into byte lane i.
- After byte N-1 is captured, goes to `DONE`.

`WR` state:
- Drives `mem_a_o` = base+i, `mem_dout_o` = `ram_w_data_i[8i+7:8i]` (latched copy) and `mem_wr_o` = 1 for i = 0..N-1.
- After the last byte, goes to `DONE`.

`DONE` state:
- Pulses `if_done_o` or `ram_done_o` according to the owner.
- Drives assembled data on `if_data_o` or `ram_r_data_o`; unused upper bytes are 0.
- Requests are ignored in `DONE`. The next state is always `IDLE`, so a request that stays high for a following instruction is accepted one cycle later.

Other rules:
- Address arithmetic is modulo 2^32 (base+i wraps at 0xFFFFFFFF).
- Outside `RD`/`WR`: `mem_wr_o` = 0, `mem_a_o` = 0, `mem_dout_o` = 0.
- Data outputs hold their last value outside `DONE`. Consumers sample them only while the matching done pulse is high.

## Timing
- Reset (asynchronous) forces: state `IDLE`; `if_done_o`, `ram_done_o`, `mem_wr_o` = 0; `if_data_o`, `ram_r_data_o`, `mem_a_o` = 0; `mem_dout_o` = 0.
- Reset asserted mid-transfer drops the transfer. No done pulse is produced and no further RAM writes occur.
- Cycle 0 is the cycle in which the request is sampled high in `IDLE`.
- Read of N bytes: addresses in cycles 1..N, last data returned in cycle N+1, done in cycle N+2.
  - LB = 3 cycles, LH = 4, LW/fetch = 6.
- Write of N bytes: `mem_wr_o` high in cycles 1..N, done in cycle N+1.
  - SB = 2, SH = 3, SW = 5.
- Back-to-back: minimum gap between done pulses is one `IDLE` cycle plus the next transfer.
- Simultaneous IF and MEM requests in `IDLE`: MEM is served first. IF stays pending and is accepted in the `IDLE` cycle after the MEM `DONE`.

## Configuration
- `MEMCTRL_IF_ABORT_EN` defined:
  - A MEM request seen while an IF fetch is in `RD` aborts the fetch at that edge, with no `if_done_o`.
  - The controller returns to `IDLE` and accepts the MEM request on the next edge.
  - IF keeps `if_req_i` high and is refetched from byte 0 afterwards.
- Not defined: a fetch always runs to completion. MEM waits in `IDLE` arbitration after the IF `DONE`.

## Test plan
- LW at 0x100, RAM bytes 0x11,0x22,0x33,0x44:
  - `mem_a_o` shows 0x100..0x103 in cycles 1..4.
  - `ram_done_o` pulses in cycle 6 with `ram_r_data_o` = 0x44332211.
- SB to 0x20 with `ram_w_data_i` = 0xDEADBEEF:
  - Single write of 0xEF at 0x20 in cycle 1.
  - `ram_done_o` in cycle 2; no other `mem_wr_o` activity.
- SH to 0xFFFFFFFF with data 0x00001234:
  - Writes 0x34 at 0xFFFFFFFF, then 0x12 at 0x00000000.
  - `ram_done_o` in cycle 3.
- `if_req_i` and `ram_r_req_i` (LBU at 0x8) raised together:
  - Load done in cycle 3, IDLE in cycle 4, fetch accepted in cycle 4, `if_done_o` in cycle 10.
- Fetch in progress, LW request arrives in cycle 2:
  - With `MEMCTRL_IF_ABORT_EN`: no `if_done_o`; LW addresses begin in cycle 4.
  - Without it: `if_done_o` in cycle 6, LW accepted in cycle 7.
- `rst` pulsed in cycle 2 of an SW:
  - All outputs 0 immediately; no done pulse.
  - After release, a new LB completes normally in 3 cycles.
